// File: rtl/iw_instr_buffer.sv
// Fetch -> instruction-window decoupling FIFO with pointer-based full/empty and synchronous flush.
// Optional zero-latency bypass when the buffer is empty, enabled by defining IW_BYPASS_EN.
module iw_instr_buffer #(
  parameter  int DEPTH = 4,
  parameter  int PKT_W = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             fetch_iw_valid,
  output logic             iw_fetch_ready,
  input  logic [PKT_W-1:0] fetch_iw_instr_packet,
  output logic             iw_valid,
  input  logic             iw_ready,
  output logic [PKT_W-1:0] iw_instr_packet,
  output logic [CNT_W-1:0] iw_count
);

  localparam int IDX_W = CNT_W - 1;

  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic             r_rst_done;
  logic [PKT_W-1:0] r_mem [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_full  = (r_wr_ptr[CNT_W-1] != r_rd_ptr[CNT_W-1]) &&
                   (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

`ifdef IW_BYPASS_EN
  assign w_bypass = w_empty & iw_ready & ~flush & r_rst_done;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = fetch_iw_valid & iw_fetch_ready & ~flush & ~w_bypass;
  assign w_pop  = ~w_empty & iw_ready & ~flush;

  // Ready is held low for the first cycle out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // Read/write pointers; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Payload storage carries no reset; only the pointers qualify its contents.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[IDX_W-1:0]] <= fetch_iw_instr_packet;
    end
  end

  // Output side: head of queue, or the incoming packet when bypassing.
  always_comb begin
    iw_fetch_ready  = r_rst_done & ~w_full;
    iw_count        = r_wr_ptr - r_rd_ptr;
    iw_valid        = 1'b0;
    iw_instr_packet = '0;
    if (w_bypass) begin
      iw_valid = fetch_iw_valid;
      if (fetch_iw_valid) begin
        iw_instr_packet = fetch_iw_instr_packet;
      end else begin
        iw_instr_packet = '0;
      end
    end else if (!w_empty) begin
      iw_valid        = ~flush;
      iw_instr_packet = r_mem[r_rd_ptr[IDX_W-1:0]];
    end else begin
      iw_valid        = 1'b0;
      iw_instr_packet = '0;
    end
  end

endmodule
